// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, fetch FSM encoding, reset level.
package if_fetch_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam logic        RstEnable   = 1'b1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StB0   = 3'd1,
    StB1   = 3'd2,
    StB2   = 3'd3,
    StB3   = 3'd4,
    StHold = 3'd5
  } fetch_state_e;

  function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] addr);
    return {addr[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: async lookup, single write port.
module icache_dm import if_fetch_pkg::*; #(
  parameter int unsigned Lines = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [InstAddrBus-1:0] rd_pc_i,
  output logic                   hit_o,
  output logic [InstBus-1:0]     rd_data_o,
  input  logic                   wr_en_i,
  input  logic [InstAddrBus-1:0] wr_pc_i,
  input  logic [InstBus-1:0]     wr_data_i
);

  localparam int unsigned IdxW = (Lines > 1) ? $clog2(Lines) : 1;
  localparam int unsigned TagW = InstAddrBus - 2 - IdxW;

  logic [Lines-1:0]   valid_q;
  logic [TagW-1:0]    tag_q  [Lines];
  logic [InstBus-1:0] data_q [Lines];

  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [TagW-1:0] rd_tag, wr_tag;

  assign rd_idx = rd_pc_i[2 +: IdxW];
  assign wr_idx = wr_pc_i[2 +: IdxW];
  assign rd_tag = rd_pc_i[InstAddrBus-1 -: TagW];
  assign wr_tag = wr_pc_i[InstAddrBus-1 -: TagW];

  assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset; a clear valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: four byte beats per word, little-endian assembly, held until decode takes it.
// Optional direct-mapped icache when IF_ICACHE_EN is defined.
module if_fetch import if_fetch_pkg::*; #(
  parameter logic [InstAddrBus-1:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned            ICACHE_LINES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_en_i,
  input  logic [InstAddrBus-1:0] branch_target_i,
  output logic                   mem_req_o,
  output logic [InstAddrBus-1:0] mem_addr_o,
  input  logic                   mem_ready_i,
  input  logic [7:0]             mem_data_i,
  output logic                   if_valid_o,
  output logic [InstAddrBus-1:0] if_pc_o,
  output logic [InstBus-1:0]     if_inst_o
);

  fetch_state_e           state_q;
  logic [InstAddrBus-1:0] pc_q;
  logic [23:0]            byte_buf_q;
  logic                   mem_req_q;
  logic [InstAddrBus-1:0] mem_addr_q;
  logic                   valid_q;
  logic [InstAddrBus-1:0] if_pc_q;
  logic [InstBus-1:0]     if_inst_q;

  logic               hit_b0;
  logic [InstBus-1:0] hit_word;

`ifdef IF_ICACHE_EN
  logic cache_hit;
  logic fill_en;

  assign fill_en = (state_q == StB3) && mem_ready_i && !branch_en_i;
  assign hit_b0  = (state_q == StB0) && cache_hit;

  icache_dm #(
    .Lines (ICACHE_LINES)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .rd_pc_i   (pc_q),
    .hit_o     (cache_hit),
    .rd_data_o (hit_word),
    .wr_en_i   (fill_en),
    .wr_pc_i   (pc_q),
    .wr_data_i ({mem_data_i, byte_buf_q})
  );
`else
  logic [31:0] unused_lines;
  assign unused_lines = ICACHE_LINES;
  assign hit_b0       = 1'b0;
  assign hit_word     = '0;
`endif

  // A B0 hit suppresses the request for the one cycle spent there.
  assign mem_req_o  = mem_req_q & ~hit_b0;
  assign mem_addr_o = mem_addr_q;
  assign if_valid_o = valid_q;
  assign if_pc_o    = if_pc_q;
  assign if_inst_o  = if_inst_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      byte_buf_q <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
    end else if (branch_en_i) begin
      state_q    <= StB0;
      pc_q       <= align_word(branch_target_i);
      byte_buf_q <= '0;
      mem_req_q  <= 1'b1;
      mem_addr_q <= align_word(branch_target_i);
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          state_q    <= StB0;
          mem_req_q  <= 1'b1;
          mem_addr_q <= pc_q;
        end
        StB0: begin
          if (hit_b0) begin
            state_q   <= StHold;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b1;
            if_pc_q   <= pc_q;
            if_inst_q <= hit_word;
          end else if (mem_ready_i) begin
            byte_buf_q[7:0] <= mem_data_i;
            state_q         <= StB1;
            mem_addr_q      <= pc_q + 32'd1;
          end
        end
        StB1: begin
          if (mem_ready_i) begin
            byte_buf_q[15:8] <= mem_data_i;
            state_q          <= StB2;
            mem_addr_q       <= pc_q + 32'd2;
          end
        end
        StB2: begin
          if (mem_ready_i) begin
            byte_buf_q[23:16] <= mem_data_i;
            state_q           <= StB3;
            mem_addr_q        <= pc_q + 32'd3;
          end
        end
        StB3: begin
          if (mem_ready_i) begin
            state_q   <= StHold;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b1;
            if_pc_q   <= pc_q;
            if_inst_q <= {mem_data_i, byte_buf_q};
          end
        end
        StHold: begin
          if (!stall_i) begin
            state_q    <= StB0;
            pc_q       <= pc_q + 32'd4;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q + 32'd4;
            valid_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: directed fetch, stall, redirect, wrap and (optional) icache hit.
module tb_if_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_en_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o, mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o, if_inst_o;

  logic        mem_req2, mem_ready2, if_valid2;
  logic [31:0] mem_addr2, if_pc2, if_inst2;
  logic [7:0]  mem_data2;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  logic valid_prev = 1'b0;
  logic done2 = 1'b0;

  always #5 clk = ~clk;

  if_fetch u_dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_en_i     (branch_en_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ready_i     (mem_ready_i),
    .mem_data_i      (mem_data_i),
    .if_valid_o      (if_valid_o),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o)
  );

  if_fetch #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (1'b0),
    .branch_en_i     (1'b0),
    .branch_target_i (32'h0),
    .mem_req_o       (mem_req2),
    .mem_addr_o      (mem_addr2),
    .mem_ready_i     (mem_ready2),
    .mem_data_i      (mem_data2),
    .if_valid_o      (if_valid2),
    .if_pc_o         (if_pc2),
    .if_inst_o       (if_inst2)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 8'h13;
      32'h0000_0001: return 8'h00;
      32'h0000_0002: return 8'h10;
      32'h0000_0003: return 8'h00;
      32'h0000_1004: return 8'h37;
      32'h0000_1005: return 8'h12;
      32'h0000_1006: return 8'h00;
      32'h0000_1007: return 8'h00;
      default:       return a[7:0];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (if_valid_o !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, if_valid_o}, 32'd1);
  endtask

  // Zero-wait arbiters: answer every request in the same cycle.
  always @(negedge clk) begin
    mem_ready_i = mem_req_o;
    mem_data_i  = mem_byte(mem_addr_o);
    mem_ready2  = mem_req2;
    mem_data2   = mem_byte(mem_addr2);
  end

  // Monitor: each fresh presentation is matched against the scoreboard.
  always @(negedge clk) begin
    if (if_valid_o === 1'b1 && valid_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected presentation: got pc %h inst %h, want none", if_pc_o, if_inst_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("present pc", if_pc_o, e.pc);
        check("present inst", if_inst_o, e.inst);
      end
    end
    valid_prev = if_valid_o;
  end

  // Wrap instance: first word at FFFF_FFFC, next request must go to 0.
  initial begin
    int n = 0;
    while (if_valid2 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wrap valid", {31'b0, if_valid2}, 32'd1);
    check("wrap pc", if_pc2, 32'hFFFF_FFFC);
    check("wrap inst", if_inst2, 32'hFFFE_FDFC);
    @(negedge clk);
    check("wrap next addr", mem_addr2, 32'h0);
    check("wrap next req", {31'b0, mem_req2}, 32'd1);
    done2 = 1'b1;
  end

  initial begin
    rst             = 1'b1;
    stall_i         = 1'b0;
    branch_en_i     = 1'b0;
    branch_target_i = '0;
    repeat (2) @(negedge clk);
    check("reset req", {31'b0, mem_req_o}, 32'd0);
    check("reset addr", mem_addr_o, 32'h0);
    check("reset valid", {31'b0, if_valid_o}, 32'd0);
    check("reset pc", if_pc_o, 32'h0);
    check("reset inst", if_inst_o, 32'h0);

    rst = 1'b0;
    sb_q.push_back('{pc: 32'h0, inst: 32'h0010_0013});
    @(negedge clk);
    check("b0 req", {31'b0, mem_req_o}, 32'd1);
    check("b0 addr", mem_addr_o, 32'h0);
    repeat (3) @(negedge clk);
    check("no early valid", {31'b0, if_valid_o}, 32'd0);
    @(negedge clk);
    check("valid on cycle 5", {31'b0, if_valid_o}, 32'd1);

    stall_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall valid", {31'b0, if_valid_o}, 32'd1);
      check("stall pc", if_pc_o, 32'h0);
      check("stall inst", if_inst_o, 32'h0010_0013);
      check("stall req", {31'b0, mem_req_o}, 32'd0);
    end
    stall_i = 1'b0;
    @(negedge clk);
    check("next addr", mem_addr_o, 32'h4);
    check("next req", {31'b0, mem_req_o}, 32'd1);
    check("next valid", {31'b0, if_valid_o}, 32'd0);

    repeat (2) @(negedge clk);
    check("in b2 addr", mem_addr_o, 32'h6);
    branch_en_i     = 1'b1;
    branch_target_i = 32'h0000_1006;
    @(negedge clk);
    branch_en_i = 1'b0;
    check("redirect valid", {31'b0, if_valid_o}, 32'd0);
    check("redirect addr", mem_addr_o, 32'h1004);
    check("redirect req", {31'b0, mem_req_o}, 32'd1);
    sb_q.push_back('{pc: 32'h1004, inst: 32'h0000_1237});
    wait_valid("redirect word valid");

    // Redirect wins over stall in HOLD.
    stall_i         = 1'b1;
    branch_en_i     = 1'b1;
    branch_target_i = 32'h0000_0020;
    sb_q.push_back('{pc: 32'h20, inst: 32'h2322_2120});
    @(negedge clk);
    branch_en_i = 1'b0;
    stall_i     = 1'b0;
    check("branch+stall valid", {31'b0, if_valid_o}, 32'd0);
    check("branch+stall addr", mem_addr_o, 32'h20);
    wait_valid("word at 0x20 valid");
    @(negedge clk);
    check("after 0x20 addr", mem_addr_o, 32'h24);
    check("after 0x20 req", {31'b0, mem_req_o}, 32'd1);

    branch_en_i     = 1'b1;
    branch_target_i = 32'h0;
    sb_q.push_back('{pc: 32'h0, inst: 32'h0010_0013});
    @(negedge clk);
    branch_en_i = 1'b0;
`ifdef IF_ICACHE_EN
    check("hit b0 req", {31'b0, mem_req_o}, 32'd0);
    check("hit b0 valid", {31'b0, if_valid_o}, 32'd0);
    @(negedge clk);
    check("hit valid", {31'b0, if_valid_o}, 32'd1);
    check("hit hold req", {31'b0, mem_req_o}, 32'd0);
`else
    check("refetch addr", mem_addr_o, 32'h0);
    wait_valid("refetch valid");
`endif

    repeat (2) @(negedge clk);
    for (int i = 0; i < 40 && !done2; i++) @(negedge clk);
    check("wrap check done", {31'b0, done2}, 32'd1);
    check("scoreboard drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; upstream producer of pc/inst for the decode stage.
- Fetches 32-bit instructions over the byte-wide memory arbiter port, assembles them little-endian and presents them to IF/ID.
- Honours decode-side stall and branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ICACHE_LINES, 16, number of direct-mapped one-word icache lines; power of 2; used only with ICACHE_EN.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- stall_i  input  1  decode stall; 1 = hold presented instruction
- branch_en_i  input  1  redirect request
- branch_target_i  input  32  redirect pc
- mem_req_o  output  1  byte fetch request to arbiter
- mem_addr_o  output  32  byte address of requested byte
- mem_ready_i  input  1  arbiter delivers byte for mem_addr_o this cycle
- mem_data_i  input  8  delivered byte
- if_valid_o  output  1  if_inst_o/if_pc_o hold a valid instruction
- if_pc_o  output  32  pc of presented instruction
- if_inst_o  output  32  presented instruction

Behaviour:
- Reset (rst=1 at posedge): pc←RESET_PC, state←IDLE, byte buffer←0, mem_req_o=0, mem_addr_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0. Reset mid-fetch discards partial bytes. With ICACHE_EN, all line valid bits←0.
- States: IDLE, B0, B1, B2, B3, HOLD.
- IDLE: next cycle →B0. mem_req_o=0.
- Bk (k=0..3): mem_req_o=1, mem_addr_o=pc+k. On mem_ready_i: buf[8k+7:8k]←mem_data_i, →B(k+1); from B3 →HOLD. Without mem_ready_i: stay.
- Entry into HOLD, same edge as the B3 beat:
  - if_inst_o←{mem_data_i, buf[23:0]}, if_pc_o←pc, if_valid_o←1.
- HOLD, stall_i=0 at edge: pc←pc+4, state←B0, if_valid_o←0.
  - Minimum cadence: 4 beats + 1 hold cycle = 5 cycles per instruction, zero-wait arbiter.
  - Decode consumes the instruction on the cycle stall_i=0 while if_valid_o=1.
- HOLD, stall_i=1: all outputs held, mem_req_o=0.
- Redirect: branch_en_i=1 at edge, any state: pc←{branch_target_i[31:2],2'b00}, state←B0, if_valid_o←0, buffer cleared. Any mem_ready_i byte in that cycle is discarded.
- Priority: rst > branch_en_i > stall_i > FSM progress.
- mem_addr_o is registered and changes only on state or pc change. The arbiter never sees an address change while mem_req_o=1 except on a redirect.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0). Byte addresses pc+k wrap likewise.

Optional Feature:
- Macro: IF_ICACHE_EN.
- Defined: direct-mapped cache of ICACHE_LINES words.
  - Index = pc[2+log2(ICACHE_LINES)-1:2]; tag = remaining upper bits; one valid bit per line.
  - In B0, if the line is valid and the tag matches: skip memory (mem_req_o=0) and enter HOLD next edge with the cached word. Hit latency 1 cycle + hold.
  - Every completed 4-byte fetch writes its line.
  - Redirect does not invalidate lines.
- Undefined: no cache storage; every instruction goes through B0–B3.

Decomposition:
- Shared defines file holds: InstAddrBus, InstBus, the fetch state encodings (3-bit), RstEnable.
- Sub-module icache_dm (storage, lookup, write port), instantiated only under IF_ICACHE_EN.

Test Plan:
- Reset release, arbiter returns bytes 13,00,10,00 at addrs 0..3, mem_ready every cycle → if_valid_o=1 on cycle 5, if_inst_o=32'h0010_0013, if_pc_o=0; next fetch addr 4.
- stall_i=1 for 3 cycles while HOLD → if_inst_o/if_pc_o unchanged, mem_req_o=0; stall_i drop → mem_addr_o=4 next cycle.
- branch_en_i=1, target 32'h0000_1006, asserted in B2 → partial bytes dropped, if_valid_o=0, mem_addr_o=32'h1004 next cycle, then the fetched word presented with if_pc_o=32'h1004.
- branch_en_i and stall_i both 1 in HOLD → redirect taken, if_valid_o=0.
- RESET_PC=32'hFFFF_FFFC → after first instruction, next mem_addr_o=0.
- IF_ICACHE_EN: loop branch back to 0x0 after first fetch → second pass if_valid_o one cycle after redirect, no mem_req_o asserted.
